// File: rtl/iq_gen_hls_deadlock_monitor_param.sv
// Deadlock monitor for HLS dataflow regions: N stream sources plus one combined
// sub-instance source, each persistence-filtered, with first-offender capture and a cycle counter.
module iq_gen_hls_deadlock_monitor_param #(
  parameter int NUM_AXIS    = 3,
  parameter int NUM_INST    = 1,
  parameter int HOLD_CYCLES = 1,
  parameter int STICKY      = 0,
  parameter int CNT_W       = 16,
  parameter int IDX_W       = $clog2(NUM_AXIS + 1)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           clear,
  input  logic [NUM_AXIS-1:0]            axis_block_sigs,
  input  logic [NUM_INST-1:0]            inst_idle_sigs,
  input  logic [NUM_INST-1:0]            inst_block_sigs,
  output logic [NUM_AXIS*NUM_AXIS-1:0]   axis_block_info,
  output logic                           block,
  output logic                           first_valid,
  output logic [IDX_W-1:0]               first_idx,
  output logic [CNT_W-1:0]               block_count
);

  localparam int NUM_SRC = NUM_AXIS + 1;
  localparam int HC_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [HC_W-1:0]     HOLD_VAL = HC_W'(HOLD_CYCLES);
  localparam logic [NUM_AXIS-1:0] ONE_HOT0 = NUM_AXIS'(1);

  logic [HC_W-1:0]    cnt_q [NUM_SRC];
  logic [HC_W-1:0]    cnt_d [NUM_SRC];
  logic [NUM_SRC-1:0] sticky_q, sticky_d;
  logic               first_valid_q, first_valid_d;
  logic [IDX_W-1:0]   first_idx_q, first_idx_d;
  logic [CNT_W-1:0]   block_count_q, block_count_d;

  logic               inst_cond;
  logic [NUM_SRC-1:0] src;
  logic [NUM_SRC-1:0] live;
  logic [NUM_SRC-1:0] flagged;

  // Flags are decoded purely from registers, so reset clears the outputs without waiting for an edge.
  always_comb begin
    inst_cond = (&(inst_block_sigs | inst_idle_sigs)) & (|inst_block_sigs);
    src       = {inst_cond, axis_block_sigs};
    for (int s = 0; s < NUM_SRC; s++) begin
      live[s] = (cnt_q[s] == HOLD_VAL);
    end
    flagged = (STICKY != 0) ? (live | sticky_q) : live;
    block   = |flagged;
    axis_block_info = '0;
    for (int i = 0; i < NUM_AXIS; i++) begin
      if (flagged[i]) axis_block_info[i*NUM_AXIS +: NUM_AXIS] = ~(ONE_HOT0 << i);
    end
  end

  // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latches).
  always_comb begin
    sticky_d      = (STICKY != 0) ? (sticky_q | live) : '0;
    first_valid_d = first_valid_q;
    first_idx_d   = first_idx_q;
    block_count_d = block_count_q;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (!src[s])      cnt_d[s] = '0;
      else if (live[s]) cnt_d[s] = HOLD_VAL;
      else              cnt_d[s] = cnt_q[s] + HC_W'(1);
    end

    // Descending scan leaves the lowest live index; the instance source sits last.
    if (!first_valid_q && (|live)) begin
      first_valid_d = 1'b1;
      for (int s = NUM_SRC - 1; s >= 0; s--) begin
        if (live[s]) first_idx_d = IDX_W'(s);
      end
    end

    if (block && !(&block_count_q)) block_count_d = block_count_q + CNT_W'(1);

    if (clear) begin
      for (int s = 0; s < NUM_SRC; s++) cnt_d[s] = '0;
      sticky_d      = '0;
      first_valid_d = 1'b0;
      first_idx_d   = '0;
      block_count_d = '0;
    end
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NUM_SRC; s++) cnt_q[s] <= '0;
      sticky_q      <= '0;
      first_valid_q <= 1'b0;
      first_idx_q   <= '0;
      block_count_q <= '0;
    end else begin
      for (int s = 0; s < NUM_SRC; s++) cnt_q[s] <= cnt_d[s];
      sticky_q      <= sticky_d;
      first_valid_q <= first_valid_d;
      first_idx_q   <= first_idx_d;
      block_count_q <= block_count_d;
    end
  end

  assign first_valid = first_valid_q;
  assign first_idx   = first_idx_q;
  assign block_count = block_count_q;

endmodule

// File: tb/tb_iq_gen_hls_deadlock_monitor_param.sv
// Bench for the deadlock monitor: three configurations share one stimulus stream and are
// compared every cycle against a run-length reference model.
module tb_iq_gen_hls_deadlock_monitor_param;

  localparam int NA = 3;
  localparam int NI = 2;
  localparam int NS = NA + 1;
  localparam int NK = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          clear = 1'b0;
  logic [NA-1:0] axis  = '0;
  logic [NI-1:0] idle  = '0;
  logic [NI-1:0] blk   = '0;

  always #5 clock = ~clock;

  logic [8:0]  info_0, info_1, info_2;
  logic        block_0, block_1, block_2;
  logic        fv_0, fv_1, fv_2;
  logic [1:0]  fi_0, fi_1, fi_2;
  logic [3:0]  bc_0;
  logic [15:0] bc_1;
  logic [4:0]  bc_2;

  iq_gen_hls_deadlock_monitor_param #(.NUM_AXIS(NA), .NUM_INST(NI), .HOLD_CYCLES(1), .STICKY(0), .CNT_W(4)) u0 (
    .clock(clock), .reset(reset), .clear(clear), .axis_block_sigs(axis), .inst_idle_sigs(idle),
    .inst_block_sigs(blk), .axis_block_info(info_0), .block(block_0), .first_valid(fv_0),
    .first_idx(fi_0), .block_count(bc_0));
  iq_gen_hls_deadlock_monitor_param #(.NUM_AXIS(NA), .NUM_INST(NI), .HOLD_CYCLES(3), .STICKY(0), .CNT_W(16)) u1 (
    .clock(clock), .reset(reset), .clear(clear), .axis_block_sigs(axis), .inst_idle_sigs(idle),
    .inst_block_sigs(blk), .axis_block_info(info_1), .block(block_1), .first_valid(fv_1),
    .first_idx(fi_1), .block_count(bc_1));
  iq_gen_hls_deadlock_monitor_param #(.NUM_AXIS(NA), .NUM_INST(NI), .HOLD_CYCLES(2), .STICKY(1), .CNT_W(5)) u2 (
    .clock(clock), .reset(reset), .clear(clear), .axis_block_sigs(axis), .inst_idle_sigs(idle),
    .inst_block_sigs(blk), .axis_block_info(info_2), .block(block_2), .first_valid(fv_2),
    .first_idx(fi_2), .block_count(bc_2));

  logic [31:0] o_info [NK];
  logic [31:0] o_block[NK];
  logic [31:0] o_fv   [NK];
  logic [31:0] o_fi   [NK];
  logic [31:0] o_bc   [NK];
  assign o_info[0] = 32'(info_0);  assign o_info[1] = 32'(info_1);  assign o_info[2] = 32'(info_2);
  assign o_block[0] = 32'(block_0); assign o_block[1] = 32'(block_1); assign o_block[2] = 32'(block_2);
  assign o_fv[0] = 32'(fv_0);      assign o_fv[1] = 32'(fv_1);      assign o_fv[2] = 32'(fv_2);
  assign o_fi[0] = 32'(fi_0);      assign o_fi[1] = 32'(fi_1);      assign o_fi[2] = 32'(fi_2);
  assign o_bc[0] = 32'(bc_0);      assign o_bc[1] = 32'(bc_1);      assign o_bc[2] = 32'(bc_2);

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: run[] is the number of consecutive sampled-high edges of each source.
  int run  [NK][NS];
  bit stk  [NK][NS];
  bit fv_m [NK];
  int fi_m [NK];
  int bc_m [NK];

  function automatic int hold_of(int k);
    case (k)
      0:       return 1;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic bit sticky_of(int k);
    return k == 2;
  endfunction

  function automatic int cmax_of(int k);
    case (k)
      0:       return 15;
      1:       return 65535;
      default: return 31;
    endcase
  endfunction

  function automatic bit src_now(int s);
    bit all_ok = 1'b1;
    bit any_b  = 1'b0;
    if (s < NA) return axis[s];
    for (int j = 0; j < NI; j++) begin
      if (!(blk[j] || idle[j])) all_ok = 1'b0;
      if (blk[j]) any_b = 1'b1;
    end
    return all_ok && any_b;
  endfunction

  function automatic bit m_live(int k, int s);
    return run[k][s] >= hold_of(k);
  endfunction

  function automatic bit m_flag(int k, int s);
    return m_live(k, s) || (sticky_of(k) && stk[k][s]);
  endfunction

  task automatic model_zero(int k);
    for (int s = 0; s < NS; s++) begin
      run[k][s] = 0;
      stk[k][s] = 1'b0;
    end
    fv_m[k] = 1'b0;
    fi_m[k] = 0;
    bc_m[k] = 0;
  endtask

  task automatic model_edge();
    for (int k = 0; k < NK; k++) begin
      if (!reset || clear) begin
        model_zero(k);
      end else begin
        bit lv[NS];
        bit b = 1'b0;
        for (int s = 0; s < NS; s++) begin
          lv[s] = m_live(k, s);
          b |= m_flag(k, s);
        end
        if (b && bc_m[k] < cmax_of(k)) bc_m[k]++;
        if (!fv_m[k]) begin
          for (int s = 0; s < NS; s++) begin
            if (lv[s] && !fv_m[k]) begin
              fv_m[k] = 1'b1;
              fi_m[k] = s;
            end
          end
        end
        if (sticky_of(k)) for (int s = 0; s < NS; s++) stk[k][s] |= lv[s];
        for (int s = 0; s < NS; s++) run[k][s] = src_now(s) ? (run[k][s] < 1000 ? run[k][s] + 1 : run[k][s]) : 0;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NK; k++) begin
      logic [8:0] ei = '0;
      logic [2:0] one = 3'b001;
      bit eb = 1'b0;
      for (int s = 0; s < NS; s++) eb |= m_flag(k, s);
      for (int i = 0; i < NA; i++) if (m_flag(k, i)) ei[i*3 +: 3] = ~(one << i);
      check($sformatf("u%0d_block", k), o_block[k], 32'(eb));
      check($sformatf("u%0d_info", k),  o_info[k],  32'(ei));
      check($sformatf("u%0d_fvalid", k), o_fv[k],   32'(fv_m[k]));
      check($sformatf("u%0d_fidx", k),  o_fi[k],    32'(fi_m[k]));
      check($sformatf("u%0d_count", k), o_bc[k],    32'(bc_m[k]));
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clock);
      model_edge();
      @(negedge clock);
      check_all();
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Called at a falling edge: drops reset between clock edges and checks outputs before the next edge.
  task automatic reset_mid(string tag);
    #2 reset = 1'b0;
    #1;
    for (int k = 0; k < NK; k++) begin
      check($sformatf("%s_u%0d_block", tag, k), o_block[k], 32'd0);
      check($sformatf("%s_u%0d_info", tag, k),  o_info[k],  32'd0);
      check($sformatf("%s_u%0d_fvalid", tag, k), o_fv[k],   32'd0);
      check($sformatf("%s_u%0d_count", tag, k), o_bc[k],   32'd0);
      model_zero(k);
    end
    tick();
    reset = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < NK; k++) model_zero(k);
    tick(2);
    reset = 1'b1;
    tick();

    // Single-cycle pulse on channel 1 with legacy timing.
    axis = 3'b010;
    tick();
    check("tp1_block", o_block[0], 32'd1);
    check("tp1_info", o_info[0], 32'h028);
    axis = 3'b000;
    tick();
    check("tp1_block_off", o_block[0], 32'd0);
    check("tp1_fvalid", o_fv[0], 32'd1);
    check("tp1_fidx", o_fi[0], 32'd1);
    check("tp1_count", o_bc[0], 32'd1);
    do_clear();

    // Deassert one cycle short of the hold threshold on u1, then hold long enough.
    axis = 3'b001;
    tick(2);
    axis = 3'b000;
    tick();
    check("short_fvalid", o_fv[1], 32'd0);
    check("short_block", o_block[1], 32'd0);
    axis = 3'b001;
    tick(5);
    axis = 3'b000;
    tick(3);
    do_clear();

    // Sticky capture on channel 2.
    axis = 3'b100;
    tick(2);
    axis = 3'b000;
    tick(10);
    check("sticky_block", o_block[2], 32'd1);
    check("sticky_field2", 32'(info_2[8:6]), 32'd3);
    do_clear();
    check("sticky_clr_block", o_block[2], 32'd0);
    check("sticky_clr_count", o_bc[2], 32'd0);
    check("sticky_clr_fvalid", o_fv[2], 32'd0);

    // Instance source: one blocked, the other idle.
    blk = 2'b01; idle = 2'b10;
    tick(4);
    check("inst_block", o_block[1], 32'd1);
    check("inst_fidx", o_fi[1], 32'd3);
    check("inst_info", o_info[1], 32'd0);
    idle = 2'b00;
    tick();
    check("inst_not_all_idle", o_block[1], 32'd0);
    blk = 2'b00;
    do_clear();

    // Simultaneous channel and instance assertion; lowest channel wins and holds.
    axis = 3'b110; blk = 2'b01; idle = 2'b10;
    tick(4);
    check("simul_fidx", o_fi[1], 32'd1);
    axis = 3'b111;
    tick(3);
    check("simul_hold_fidx", o_fi[0], 32'd1);
    axis = '0; blk = '0; idle = '0;
    do_clear();

    // Counter saturation.
    axis = 3'b001;
    tick(40);
    check("sat_count_u0", o_bc[0], 32'd15);
    check("sat_count_u2", o_bc[2], 32'd31);
    reset_mid("rst_mid");
    axis = '0;
    tick(2);

    // Randomised run with occasional clears and mid-cycle resets.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NA; i++) if ($urandom_range(0, 3) == 0) axis[i] = ~axis[i];
      for (int j = 0; j < NI; j++) begin
        if ($urandom_range(0, 4) == 0) blk[j]  = ~blk[j];
        if ($urandom_range(0, 4) == 0) idle[j] = ~idle[j];
      end
      clear = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 199) == 0) reset_mid("rst_rand");
      else tick();
    end
    clear = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
